// File: rtl/nios_mul_pkg.sv
// nios_mul_pkg: op encodings and FSM states shared by the
// sequential multiplier, its interface users and the bench.
package nios_mul_pkg;

  typedef logic [1:0] mul_op_t;

  localparam mul_op_t MUL_OP_LO  = 2'b00;
  localparam mul_op_t MUL_OP_XUU = 2'b01;
  localparam mul_op_t MUL_OP_XSU = 2'b10;
  localparam mul_op_t MUL_OP_XSS = 2'b11;

  typedef logic [2:0] mul_state_t;

  localparam mul_state_t IDLE  = 3'd0;
  localparam mul_state_t ISSUE = 3'd1;
  localparam mul_state_t LAST  = 3'd2;
  localparam mul_state_t FIN   = 3'd3;
  localparam mul_state_t DONE  = 3'd4;

endpackage

// File: rtl/nios_mul_if.sv
// nios_mul_if: request/response handshake bundle between
// the CPU ALU side and the sequential multiplier.
interface nios_mul_if
  import nios_mul_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  mul_op_t           op;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;

  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/nios_mul_cell.sv
// nios_mul_cell: registered CELL_W x CELL_W unsigned multiply
// that carries the partial product's shift tag alongside.
module nios_mul_cell #(
  parameter int CELL_W = 16,
  parameter int TAG_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CELL_W-1:0]   a,
  input  logic [CELL_W-1:0]   b,
  input  logic [TAG_W-1:0]    tag,
  output logic [2*CELL_W-1:0] prod,
  output logic [TAG_W-1:0]    prod_tag,
  output logic                vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_tag <= '0;
      vld      <= 1'b0;
    end else begin
      vld <= en;
      if (en) begin
        prod     <= (2*CELL_W)'(a) * (2*CELL_W)'(b);
        prod_tag <= tag;
      end
    end
  end

endmodule

// File: rtl/nios_mul_seq_unit.sv
// nios_mul_seq_unit: sign-magnitude sequential multiplier, one
// CELL_W cell time-multiplexed over all partial products.
module nios_mul_seq_unit
  import nios_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CELL_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  output logic       busy,
  nios_mul_if.slave  bus
);

  localparam int M     = DATA_W / CELL_W;
  localparam int N     = M * M;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int TAG_W = (M > 1) ? $clog2(2*M-1) : 1;
  localparam int ACC_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);

  mul_state_t          state;
  logic [CNT_W-1:0]    k;
  mul_op_t             op_q;
  logic                neg_q;
  logic [DATA_W-1:0]   mag1;
  logic [DATA_W-1:0]   mag2;
  logic [DATA_W-1:0]   result_q;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    p_full;
  logic [ACC_W-1:0]    p_fin;
  logic [CELL_W-1:0]   dig1;
  logic [CELL_W-1:0]   dig2;
  logic [TAG_W-1:0]    tag;
  logic [TAG_W-1:0]    p_tag;
  logic [2*CELL_W-1:0] p_prod;
  logic                p_vld;
  logic                cell_en;
  logic                s1;
  logic                s2;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign busy          = (state != IDLE);

  assign s1 = bus.op[1] & bus.src1[DATA_W-1];
  assign s2 = (bus.op == MUL_OP_XSS) & bus.src2[DATA_W-1];

  // k walks src1 digits fastest, src2 digits slowest
  always_comb begin
    dig1 = '0;
    dig2 = '0;
    for (int d = 0; d < M; d++) begin
      if (int'(k) % M == d) dig1 = mag1[d*CELL_W +: CELL_W];
      if (int'(k) / M == d) dig2 = mag2[d*CELL_W +: CELL_W];
    end
    tag = TAG_W'(int'(k) % M + int'(k) / M);
  end

  assign cell_en = (state == ISSUE) && !flush;
  assign p_full  = ACC_W'(p_prod) << (CELL_W * int'(p_tag));
  assign p_fin   = neg_q ? -acc : acc;

  nios_mul_cell #(
    .CELL_W (CELL_W),
    .TAG_W  (TAG_W)
  ) u_cell (
    .clk      (clk),
    .rst_n    (reset_n),
    .en       (cell_en),
    .a        (dig1),
    .b        (dig2),
    .tag      (tag),
    .prod     (p_prod),
    .prod_tag (p_tag),
    .vld      (p_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      k        <= '0;
      op_q     <= MUL_OP_LO;
      neg_q    <= 1'b0;
      mag1     <= '0;
      mag2     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (flush) begin
      state <= IDLE;
      k     <= '0;
      acc   <= '0;
    end else begin
      if (p_vld) acc <= acc + p_full;
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q  <= bus.op;
          neg_q <= s1 ^ s2;
          mag1  <= s1 ? -bus.src1 : bus.src1;
          mag2  <= s2 ? -bus.src2 : bus.src2;
          acc   <= '0;
          k     <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          k <= k + 1'b1;
          if (k == K_LAST) state <= LAST;
        end
        LAST: state <= FIN;
        FIN: begin
          result_q <= (op_q == MUL_OP_LO) ? p_fin[DATA_W-1:0]
                                          : p_fin[ACC_W-1:DATA_W];
          state    <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_mul_seq_unit.sv
// tb_nios_mul_seq_unit: scoreboard bench, directed vectors at
// DATA_W 32 and a reference-model sweep at DATA_W 64.
module tb_nios_mul_seq_unit;
  import nios_mul_pkg::*;

  typedef struct {
    logic [63:0] exp;
    int          t0;
  } sb_t;

  typedef struct {
    mul_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vec [8] = '{
    '{MUL_OP_LO,  32'h00010003, 32'h00020005, 32'h000B000F},
    '{MUL_OP_XUU, 32'h00010003, 32'h00020005, 32'h00000002},
    '{MUL_OP_LO,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
    '{MUL_OP_XUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{MUL_OP_XSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
    '{MUL_OP_XSS, 32'h80000000, 32'h80000000, 32'h40000000},
    '{MUL_OP_XSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
    '{MUL_OP_XSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001}
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy32;
  logic busy64;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   seen32  = 1'b0;
  bit   seen64  = 1'b0;
  sb_t  q32[$];
  sb_t  q64[$];

  nios_mul_if #(.DATA_W(32)) b32();
  nios_mul_if #(.DATA_W(64)) b64();

  nios_mul_seq_unit #(.DATA_W(32), .CELL_W(16)) u32 (
    .clk(clk), .reset_n(rst_n), .flush(flush), .busy(busy32), .bus(b32)
  );

  nios_mul_seq_unit #(.DATA_W(64), .CELL_W(16)) u64 (
    .clk(clk), .reset_n(rst_n), .flush(flush), .busy(busy64), .bus(b64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_total++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  function automatic logic [63:0] ref64(input mul_op_t o,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = {{64{o[1] & a[63]}}, a};
    eb = {{64{(o == MUL_OP_XSS) & b[63]}}, b};
    p  = ea * eb;
    return (o == MUL_OP_LO) ? p[63:0] : p[127:64];
  endfunction

  always @(negedge clk) begin : mon32
    sb_t s;
    if (!rst_n || !b32.out_valid) seen32 = 1'b0;
    else begin
      if (!seen32) begin
        seen32 = 1'b1;
        if (q32.size() == 0) begin
          n_total++;
          $display("FAIL unexp32: got out_valid=1 want 0");
        end else check("lat32", 64'(cyc - q32[0].t0), 64'd7);
      end
      if (b32.out_ready && q32.size() != 0) begin
        s = q32.pop_front();
        check("res32", 64'(b32.result), s.exp);
      end
    end
  end

  always @(negedge clk) begin : mon64
    sb_t s;
    if (!rst_n || !b64.out_valid) seen64 = 1'b0;
    else begin
      if (!seen64) begin
        seen64 = 1'b1;
        if (q64.size() == 0) begin
          n_total++;
          $display("FAIL unexp64: got out_valid=1 want 0");
        end else check("lat64", 64'(cyc - q64[0].t0), 64'd19);
      end
      if (b64.out_ready && q64.size() != 0) begin
        s = q64.pop_front();
        check("res64", b64.result, s.exp);
      end
    end
  end

  task automatic send32(input mul_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e,
                        input bit push, output int waits);
    b32.op = o; b32.src1 = a; b32.src2 = b; b32.in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!b32.in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) timeout("accept32");
    else if (push) q32.push_back('{64'(e), cyc});
    @(posedge clk); #1;
    b32.in_valid = 1'b0; b32.op = MUL_OP_XSS;
    b32.src1 = 32'hDEADBEEF; b32.src2 = 32'hCAFEF00D;
  endtask

  task automatic send64(input mul_op_t o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] e);
    int waits;
    b64.op = o; b64.src1 = a; b64.src2 = b; b64.in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!b64.in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) timeout("accept64");
    else q64.push_back('{e, cyc});
    @(posedge clk); #1;
    b64.in_valid = 1'b0; b64.src1 = ~a; b64.src2 = ~b;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) timeout("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    mul_op_t     o;
    logic [63:0] a;
    logic [63:0] b;
    b32.in_valid = 1'b0; b32.op = MUL_OP_LO; b32.out_ready = 1'b1;
    b32.src1 = '0; b32.src2 = '0;
    b64.in_valid = 1'b0; b64.op = MUL_OP_LO; b64.out_ready = 1'b1;
    b64.src1 = '0; b64.src2 = '0;
    #2;
    check("rst_in_ready", b32.in_ready, 1);
    check("rst_out_valid", b32.out_valid, 0);
    check("rst_busy", busy32, 0);
    check("rst_result", b32.result, 0);
    check("rst_result64", b64.result, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vec[i]) send32(vec[i].op, vec[i].a, vec[i].b, vec[i].e, 1'b1, w);
    drain();

    // flush wins over in_valid while idle
    flush = 1'b1; b32.in_valid = 1'b1; b32.op = MUL_OP_LO;
    b32.src1 = 32'd3; b32.src2 = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; b32.in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", busy32, 0);
    @(posedge clk); #1;

    // flush on third ISSUE cycle
    send32(MUL_OP_LO, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; b32.in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", busy32, 0);
    check("flush_in_ready", b32.in_ready, 1);
    check("flush_out_valid", b32.out_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    send32(MUL_OP_LO, 32'd7, 32'd6, 32'd42, 1'b1, w);
    send32(MUL_OP_XSS, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b1, w);
    drain();

    // back-pressure
    b32.out_ready = 1'b0;
    send32(MUL_OP_LO, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b1, w);
    w = 0;
    @(negedge clk);
    while (!b32.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) timeout("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_result", b32.result, 32'h000B000F);
      check("bp_in_ready", b32.in_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", b32.out_valid, 0);
    send32(MUL_OP_XUU, 32'h00010003, 32'h00020005, 32'h2, 1'b1, w);
    check("bp_reaccept_wait", 64'(w), 0);
    drain();

    // asynchronous reset mid-ISSUE
    send32(MUL_OP_XUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, w);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("amid_out_valid", b32.out_valid, 0);
    check("amid_busy", busy32, 0);
    check("amid_result", b32.result, 0);
    check("amid_in_ready", b32.in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send32(MUL_OP_XSS, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 1'b1, w);
    drain();

    // DATA_W 64
    send64(MUL_OP_XSS, 64'h8000000000000000, 64'h8000000000000000,
           64'h4000000000000000);
    send64(MUL_OP_LO, '1, '1, 64'h1);
    send64(MUL_OP_XUU, '1, '1, 64'hFFFFFFFFFFFFFFFE);
    send64(MUL_OP_XSU, '1, 64'h2, '1);
    for (int i = 0; i < 24; i++) begin
      o = mul_op_t'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 6 == 0) a = 64'h8000000000000000;
      if (i % 8 == 3) b = '1;
      send64(o, a, b, ref64(o, a, b));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
